otp_stream_cipher: RTL and testbench
====================================

// Module: otp_stream_cipher
// PURPOSE
// - Serial-key one-time-pad encryptor: KEY_BITS key bits are shifted in one per cycle; data words are then XORed with key bits.
// - Each key bit is consumed once and zeroed after use. The key is never reused, and the block refuses data once the key runs out.
// - Sits directly downstream of the D flip-flop storage cells. Its key register is the bank that those cells form.
// - Feeds ciphertext to the output/transmit stage over a valid/ready handshake.
// PARAMETERS
// KEY_BITS  32  key length in bits (>= DATA_W)
// DATA_W    8   data word width; key bits consumed per accepted word
// PORTS
// clk            in   1                     clock, all state updates on rising edge
// reset          in   1                     synchronous, active-high reset
// key_bit        in   1                     serial key bit, LSB-first
// key_valid      in   1                     key_bit valid
// key_ready      out  1                     high in LOAD state only
// rekey          in   1                     one-cycle pulse: discard key, return to LOAD
// din            in   DATA_W                plaintext word
// din_valid      in   1                     din valid
// din_ready      out  1                     block accepts din this cycle
// dout           out  DATA_W                ciphertext word (registered)
// dout_valid     out  1                     dout valid
// dout_ready     in   1                     downstream accepts dout
// key_left       out  $clog2(KEY_BITS+1)    LOAD: bits loaded so far; otherwise unused key bits
// key_exhausted  out  1                     high in EXHAUSTED state
// BEHAVIOUR
// - Reset (synchronous, active-high, dominates all inputs):
//   - state=LOAD, key=0, key_left=0, dout=0, dout_valid=0, key_exhausted=0.
//   - Resulting outputs: key_ready=1, din_ready=0.
// - States: LOAD -> READY -> EXHAUSTED. rekey from any state -> LOAD.
// - LOAD:
//   - On key_valid&key_ready: key <= {key_bit, key[KEY_BITS-1:1]}, key_left++.
//   - The first accepted bit therefore ends in key[0].
//   - When key_left reaches KEY_BITS (on the edge accepting the last bit): go to READY.
//   - key_valid gaps are allowed.
// - din_ready = (state==READY) && !rekey && (!dout_valid || dout_ready).
// - Accept (din_valid&din_ready), one-cycle latency:
//   - dout <= din ^ key[DATA_W-1:0]; dout_valid <= 1.
//   - key <= key >> DATA_W (zero fill); key_left -= DATA_W.
// - Output hold: dout and dout_valid are held stable while dout_valid && !dout_ready.
//   - dout_valid clears on dout_ready with no new accept.
//   - Accept and drain in the same cycle give back-to-back words with no bubble.
// - Exhaustion: after an accept, if new key_left < DATA_W:
//   - go to EXHAUSTED and zero any leftover key bits.
//   - key_left=0; key_exhausted=1; din_ready=0.
// - rekey has priority over a same-cycle din handshake; din is not accepted.
//   - rekey clears key, key_left and key_exhausted.
//   - A pending dout stays valid until drained.
// - rekey or reset in the middle of LOAD discards the partial key; the bit count restarts at 0.
// - key_valid is ignored outside LOAD; din_valid is ignored outside READY.
// STRUCTURE
// - Package otp_pkg:
//   - otp_state_t enum {LOAD, READY, EXHAUSTED}.
//   - Width helper localparam KEY_CNT_W = $clog2(KEY_BITS+1).
// - Sub-module otp_key_reg: KEY_BITS register with serial shift-in, parallel DATA_W-bit shift-out and zero fill, and synchronous clear.
// - Top level holds the FSM, the key_left counter and the dout register/handshake.
// TESTING (KEY_BITS=16, DATA_W=8 unless noted)
// 1. Reset -> key_ready=1, din_ready=0, dout_valid=0, dout=0, key_left=0, key_exhausted=0.
// 2. Load 16'hA5C3 LSB-first, dout_ready=1:
//    - din 8'h3C -> next cycle dout=8'hFF, key_left=8.
//    - din 8'h00 -> dout=8'hA5, key_exhausted=1, din_ready=0.
// 3. Same key, dout_ready=0 after the first word:
//    - dout stays 8'hFF, din_ready=0, key_left stays 8.
//    - Raising dout_ready with din_valid=1 gives 8'hA5 the next cycle, no bubble.
// 4. Load with key_valid toggling every other cycle -> READY only after 16 accepted bits; key_left steps 0..16.
// 5. rekey with din_valid=1 in READY -> no accept, key_left=0, key_ready=1; an old pending dout still drains.
// 6. reset after 9 key bits, then load 16'h00FF, din 8'hFF -> dout=8'h00.
// 7. KEY_BITS=20, DATA_W=8: two words accepted, then EXHAUSTED with the 4 leftover bits zeroed, key_left=0.

Source files
------------

// File: rtl/otp_pkg.sv
// One-time-pad cipher shared types and width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package otp_pkg;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    READY     = 2'd1,
    EXHAUSTED = 2'd2
  } otp_state_t;

  localparam int KEY_BITS_DEF = 32;
  localparam int DATA_W_DEF   = 8;

  // Counter must hold every value 0..KEY_BITS inclusive.
  localparam int KEY_CNT_W = $clog2(KEY_BITS_DEF + 1);

  function automatic int key_cnt_w(input int key_bits);
    return $clog2(key_bits + 1);
  endfunction

endpackage

// File: rtl/otp_stream_cipher_if.sv
// Key load, plaintext in, ciphertext out and key status bundle for the OTP cipher.
// Latency: n/a (wiring only).
// Backpressure: din_valid/din_ready on input, dout_valid/dout_ready on output.
// master = upstream/downstream side driving key and plaintext; slave = the cipher.
interface otp_stream_cipher_if #(
  parameter int DATA_W    = 8,
  parameter int KEY_CNT_W = 6
);
  logic                 key_bit;
  logic                 key_valid;
  logic                 key_ready;
  logic                 rekey;
  logic [DATA_W-1:0]    din;
  logic                 din_valid;
  logic                 din_ready;
  logic [DATA_W-1:0]    dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [KEY_CNT_W-1:0] key_left;
  logic                 key_exhausted;

  modport master (
    output key_bit, key_valid, rekey, din, din_valid, dout_ready,
    input  key_ready, din_ready, dout, dout_valid, key_left, key_exhausted
  );

  modport slave (
    input  key_bit, key_valid, rekey, din, din_valid, dout_ready,
    output key_ready, din_ready, dout, dout_valid, key_left, key_exhausted
  );
endinterface

// File: rtl/otp_key_reg.sv
// Key bank: serial shift-in at the top, DATA_W-bit shift-out at the bottom, zero fill.
// Latency: one cycle per update; key_lo is the next DATA_W key bits, combinational from state.
// Backpressure: none; clr wins over shift-in, shift-in wins over shift-out.
// Ports: clk, clr (sync), shift_in_en/shift_in_bit, shift_out_en, key_lo.
module otp_key_reg #(
  parameter int KEY_BITS = 32,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              shift_in_en,
  input  logic              shift_in_bit,
  input  logic              shift_out_en,
  output logic [DATA_W-1:0] key_lo
);

  logic [KEY_BITS-1:0] key;

  // Bits enter at the MSB so the first bit loaded ends in key[0] after KEY_BITS shifts.
  always_ff @(posedge clk) begin
    if (clr) begin
      key <= '0;
    end else if (shift_in_en) begin
      key <= {shift_in_bit, key[KEY_BITS-1:1]};
    end else if (shift_out_en) begin
      key <= key >> DATA_W;
    end
  end

  assign key_lo = key[DATA_W-1:0];

endmodule

// File: rtl/otp_stream_cipher.sv
// Serial-key one-time-pad encryptor: load KEY_BITS key bits, then XOR each word with fresh key.
// Latency: one cycle din accept -> registered dout; key bits load one per cycle.
// Backpressure: dout held while !dout_ready; din_ready drops when output is stalled, on rekey, or outside READY.
// Ports: clk, reset (sync, active-high), bus (otp_stream_cipher_if.slave).
module otp_stream_cipher
  import otp_pkg::*;
#(
  parameter int KEY_BITS = 32,
  parameter int DATA_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  otp_stream_cipher_if.slave bus
);

  localparam int              CNT_W    = key_cnt_w(KEY_BITS);
  localparam logic [CNT_W-1:0] CNT_DW   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_BITS - 1);

  otp_state_t        state_q, state_d;
  logic [CNT_W-1:0]  key_left_q;
  logic [CNT_W-1:0]  key_left_sub;
  logic [DATA_W-1:0] key_lo;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              key_ready_c;
  logic              din_ready_c;
  logic              exhausted_c;
  logic              load_acc;
  logic              din_acc;
  logic              exhaust;
  logic              key_clr;

  // rekey beats a same-cycle key bit as well as a same-cycle data word.
  assign load_acc     = (state_q == LOAD) && bus.key_valid && !bus.rekey;
  assign din_acc      = bus.din_valid && din_ready_c;
  assign key_left_sub = key_left_q - CNT_DW;
  assign exhaust      = din_acc && (key_left_sub < CNT_DW);
  // Exhaustion wipes any partial-word remainder so it can never leak out.
  assign key_clr      = reset || bus.rekey || exhaust;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.rekey) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:      if (load_acc && key_left_q == CNT_LAST) state_d = READY;
        READY:     if (exhaust) state_d = EXHAUSTED;
        EXHAUSTED: state_d = EXHAUSTED;
        default:   state_d = LOAD;
      endcase
    end
  end

  // Output logic
  always_comb begin
    key_ready_c = (state_q == LOAD);
    din_ready_c = (state_q == READY) && !bus.rekey && (!dout_valid_q || bus.dout_ready);
    exhausted_c = (state_q == EXHAUSTED);
  end

  // key_left counts up while loading and down as words consume key.
  always_ff @(posedge clk) begin
    if (reset || bus.rekey) begin
      key_left_q <= '0;
    end else if (load_acc) begin
      key_left_q <= key_left_q + 1'b1;
    end else if (din_acc) begin
      key_left_q <= exhaust ? '0 : key_left_sub;
    end
  end

  // Output register: a new accept overwrites a word being drained this cycle, so no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (din_acc) begin
      dout_q       <= bus.din ^ key_lo;
      dout_valid_q <= 1'b1;
    end else if (bus.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  otp_key_reg #(
    .KEY_BITS (KEY_BITS),
    .DATA_W   (DATA_W)
  ) u_key_reg (
    .clk          (clk),
    .clr          (key_clr),
    .shift_in_en  (load_acc),
    .shift_in_bit (bus.key_bit),
    .shift_out_en (din_acc),
    .key_lo       (key_lo)
  );

  assign bus.key_ready     = key_ready_c;
  assign bus.din_ready     = din_ready_c;
  assign bus.dout          = dout_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.key_left      = key_left_q;
  assign bus.key_exhausted = exhausted_c;

endmodule

// File: tb/tb_otp_stream_cipher.sv
// Bench for otp_stream_cipher: a 16-bit-key and a 20-bit-key instance, scoreboarded outputs.
// Latency: expects dout one cycle after each din accept.
// Backpressure: drives dout_ready low to stall output and checks din_ready/hold.
module tb_otp_stream_cipher;

  logic clk;
  logic reset;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [7:0]  q16[$];
  logic [7:0]  q20[$];
  logic [15:0] kmodel16;
  logic [19:0] kmodel20;

  otp_stream_cipher_if #(.DATA_W(8), .KEY_CNT_W(5)) b16 ();
  otp_stream_cipher_if #(.DATA_W(8), .KEY_CNT_W(5)) b20 ();

  otp_stream_cipher #(.KEY_BITS(16), .DATA_W(8)) u16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  otp_stream_cipher #(.KEY_BITS(20), .DATA_W(8)) u20 (
    .clk   (clk),
    .reset (reset),
    .bus   (b20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: pop on every output handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (!reset && b16.dout_valid && b16.dout_ready) begin
      if (q16.size() == 0) check("dout16_unexpected", 32'(q16.size()), 32'd1);
      else check("dout16", 32'(b16.dout), 32'(q16.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!reset && b20.dout_valid && b20.dout_ready) begin
      if (q20.size() == 0) check("dout20_unexpected", 32'(q20.size()), 32'd1);
      else check("dout20", 32'(b20.dout), 32'(q20.pop_front()));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    b16.key_valid = 1'b0;
    b16.din_valid = 1'b0;
    b16.rekey     = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load16(input logic [15:0] k, input int gap, input bit chk_steps);
    for (int i = 0; i < 16; i++) begin
      b16.key_bit   = k[i];
      b16.key_valid = 1'b1;
      @(negedge clk);
      if (chk_steps) check("key_left_step", 32'(b16.key_left), 32'(i));
      tick();
      b16.key_valid = 1'b0;
      if (i < 15) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (chk_steps) check("key_ready_gap", 32'(b16.key_ready), 32'd1);
          tick();
        end
      end
    end
    kmodel16 = k;
  endtask

  task automatic send16(input logic [7:0] d);
    int n;
    n = 0;
    b16.din       = d;
    b16.din_valid = 1'b1;
    @(negedge clk);
    while (!b16.din_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!b16.din_ready) begin
      check("send16_timeout", 32'(b16.din_ready), 32'd1);
    end else begin
      q16.push_back(d ^ kmodel16[7:0]);
      kmodel16 = kmodel16 >> 8;
    end
    tick();
    b16.din_valid = 1'b0;
  endtask

  task automatic send20(input logic [7:0] d);
    int n;
    n = 0;
    b20.din       = d;
    b20.din_valid = 1'b1;
    @(negedge clk);
    while (!b20.din_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!b20.din_ready) begin
      check("send20_timeout", 32'(b20.din_ready), 32'd1);
    end else begin
      q20.push_back(d ^ kmodel20[7:0]);
      kmodel20 = kmodel20 >> 8;
    end
    tick();
    b20.din_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b16.key_bit = 1'b0; b16.key_valid = 1'b0; b16.rekey = 1'b0;
    b16.din = '0; b16.din_valid = 1'b0; b16.dout_ready = 1'b1;
    b20.key_bit = 1'b0; b20.key_valid = 1'b0; b20.rekey = 1'b0;
    b20.din = '0; b20.din_valid = 1'b0; b20.dout_ready = 1'b1;
    kmodel16 = '0;
    kmodel20 = '0;

    // 1. reset state
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_key_ready",  32'(b16.key_ready), 32'd1);
    check("rst_din_ready",  32'(b16.din_ready), 32'd0);
    check("rst_dout_valid", 32'(b16.dout_valid), 32'd0);
    check("rst_dout",       32'(b16.dout), 32'd0);
    check("rst_key_left",   32'(b16.key_left), 32'd0);
    check("rst_exhausted",  32'(b16.key_exhausted), 32'd0);
    tick();

    // 2. basic encryption to exhaustion
    load16(16'hA5C3, 0, 1'b0);
    @(negedge clk);
    check("t2_key_left_full", 32'(b16.key_left), 32'd16);
    check("t2_key_ready",     32'(b16.key_ready), 32'd0);
    check("t2_din_ready",     32'(b16.din_ready), 32'd1);
    tick();
    send16(8'h3C);
    @(negedge clk);
    check("t2_key_left_8", 32'(b16.key_left), 32'd8);
    check("t2_dout_ff",    32'(b16.dout), 32'hFF);
    tick();
    send16(8'h00);
    @(negedge clk);
    check("t2_exhausted",  32'(b16.key_exhausted), 32'd1);
    check("t2_din_ready0", 32'(b16.din_ready), 32'd0);
    check("t2_key_left0",  32'(b16.key_left), 32'd0);
    b16.din_valid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("t2_no_accept_exh", 32'(b16.dout_valid), 32'd0);
    b16.din_valid = 1'b0;

    // 3. output stall and back-to-back drain
    do_reset();
    load16(16'hA5C3, 0, 1'b0);
    b16.dout_ready = 1'b0;
    send16(8'h3C);
    b16.din       = 8'h00;
    b16.din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_din_ready", 32'(b16.din_ready), 32'd0);
      check("t3_hold_key_left",  32'(b16.key_left), 32'd8);
      check("t3_hold_dout",      32'(b16.dout), 32'hFF);
      check("t3_hold_valid",     32'(b16.dout_valid), 32'd1);
      tick();
    end
    b16.dout_ready = 1'b1;
    send16(8'h00);
    @(negedge clk);
    check("t3_no_bubble", 32'(b16.dout_valid), 32'd1);
    tick();

    // 4. gapped key load
    do_reset();
    load16(16'h5A96, 1, 1'b1);
    @(negedge clk);
    check("t4_key_left_16", 32'(b16.key_left), 32'd16);
    check("t4_key_ready0",  32'(b16.key_ready), 32'd0);
    tick();

    // 5. rekey beats din; pending dout survives and drains
    b16.dout_ready = 1'b0;
    send16(8'h11);
    b16.rekey     = 1'b1;
    b16.din       = 8'h22;
    b16.din_valid = 1'b1;
    @(negedge clk);
    check("t5_din_ready_rekey", 32'(b16.din_ready), 32'd0);
    tick();
    b16.rekey     = 1'b0;
    b16.din_valid = 1'b0;
    @(negedge clk);
    check("t5_key_left0",   32'(b16.key_left), 32'd0);
    check("t5_key_ready",   32'(b16.key_ready), 32'd1);
    check("t5_exhausted0",  32'(b16.key_exhausted), 32'd0);
    check("t5_pending_vld", 32'(b16.dout_valid), 32'd1);
    check("t5_pending_dat", 32'(b16.dout), 32'h87);
    tick();
    b16.dout_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t5_drained", 32'(b16.dout_valid), 32'd0);
    tick();

    // 6. reset mid-load discards partial key
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b16.key_bit   = 1'($urandom_range(1, 0));
      b16.key_valid = 1'b1;
      tick();
    end
    b16.key_valid = 1'b0;
    @(negedge clk);
    check("t6_partial_cnt", 32'(b16.key_left), 32'd9);
    tick();
    do_reset();
    @(negedge clk);
    check("t6_cnt_restart", 32'(b16.key_left), 32'd0);
    tick();
    load16(16'h00FF, 0, 1'b0);
    send16(8'hFF);
    @(negedge clk);
    check("t6_dout_zero", 32'(b16.dout), 32'h00);
    tick();

    // 7. 20-bit key: two words then exhaustion with leftover zeroed
    for (int i = 0; i < 20; i++) begin
      b20.key_bit   = kmodel20[0] ^ 1'b0;
      b20.key_bit   = 1'((20'hABCDE >> i) & 20'h1);
      b20.key_valid = 1'b1;
      tick();
    end
    b20.key_valid = 1'b0;
    kmodel20 = 20'hABCDE;
    @(negedge clk);
    check("t7_key_left20", 32'(b20.key_left), 32'd20);
    tick();
    send20(8'h12);
    @(negedge clk);
    check("t7_key_left12", 32'(b20.key_left), 32'd12);
    tick();
    send20(8'h34);
    @(negedge clk);
    check("t7_key_left0",   32'(b20.key_left), 32'd0);
    check("t7_exhausted",   32'(b20.key_exhausted), 32'd1);
    check("t7_din_ready0",  32'(b20.din_ready), 32'd0);
    check("t7_key_zeroed",  32'(u20.u_key_reg.key), 32'd0);
    tick();

    repeat (3) tick();
    check("q16_empty", 32'(q16.size()), 32'd0);
    check("q20_empty", 32'(q20.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
